// File: rtl/bf16_pkg.sv
// ----------------------------------------------------------------------------
// bf16_pkg : shared bf16 constants and state encodings | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bf16_pkg;
    localparam int          BF16_W    = 16;
    localparam logic [15:0] BF16_ONE  = 16'h3F80;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_CALC = 2'd1,
        M_OUT  = 2'd2
    } mult_state_t;
endpackage

`default_nettype wire

// File: rtl/multiplier_bf16.sv
// ----------------------------------------------------------------------------
// multiplier_bf16 : handshaked bf16 multiplier, RNE, denormals flush to zero | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multiplier_bf16
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_stb,
    output logic        in_busy,
    output logic [15:0] result,
    output logic        out_stb,
    input  logic        out_busy
);
    mult_state_t state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, result_q, result_d;

    logic              sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              guard, sticky, rnd;
    logic [15:0]       prod, product;
    logic [7:0]        mant;
    logic signed [9:0] exp_w;

    always_comb begin
        sign   = a_q[15] ^ b_q[15];
        a_nan  = (a_q[14:7] == 8'hFF) && (a_q[6:0] != 7'd0);
        b_nan  = (b_q[14:7] == 8'hFF) && (b_q[6:0] != 7'd0);
        a_inf  = (a_q[14:7] == 8'hFF) && (a_q[6:0] == 7'd0);
        b_inf  = (b_q[14:7] == 8'hFF) && (b_q[6:0] == 7'd0);
        a_zero = (a_q[14:7] == 8'h00);
        b_zero = (b_q[14:7] == 8'h00);
        prod   = {8'd0, 1'b1, a_q[6:0]} * {8'd0, 1'b1, b_q[6:0]};
        exp_w  = $signed({2'b00, a_q[14:7]}) + $signed({2'b00, b_q[14:7]}) - 10'sd127;
        if (prod[15]) begin
            mant   = {1'b0, prod[14:8]};
            guard  = prod[7];
            sticky = |prod[6:0];
            exp_w  = exp_w + 10'sd1;
        end else begin
            mant   = {1'b0, prod[13:7]};
            guard  = prod[6];
            sticky = |prod[5:0];
        end
        // round to nearest, ties to even; a carry out renormalises the exponent
        rnd  = guard & (sticky | mant[0]);
        mant = mant + {7'd0, rnd};
        if (mant[7]) begin
            exp_w = exp_w + 10'sd1;
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            product = BF16_QNAN;
        end else if (a_inf || b_inf || exp_w >= 10'sd255) begin
            product = {sign, 8'hFF, 7'd0};
        end else if (a_zero || b_zero || exp_w <= 10'sd0) begin
            product = {sign, 15'd0};
        end else begin
            product = {sign, exp_w[7:0], mant[6:0]};
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            M_IDLE: if (in_stb) begin
                a_d     = a;
                b_d     = b;
                state_d = M_CALC;
            end
            M_CALC: begin
                result_d = product;
                state_d  = M_OUT;
            end
            M_OUT: if (!out_busy) begin
                state_d = M_IDLE;
            end
            default: state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= M_IDLE;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            result_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign in_busy = (state_q != M_IDLE);
    assign out_stb = (state_q == M_OUT);
    assign result  = result_q;
endmodule

`default_nettype wire

// File: rtl/bf16_chain_multiplier.sv
// ----------------------------------------------------------------------------
// bf16_chain_multiplier : left-to-right bf16 product of up to N_OPS operands | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bf16_chain_multiplier
    import bf16_pkg::*;
#(
    parameter int N_OPS = 8,
    parameter int CNT_W = $clog2(N_OPS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [16*N_OPS-1:0]     in_data,
    input  logic [CNT_W-1:0]        in_count,
    input  logic                    in_stb,
    output logic                    busy,
    output logic [15:0]             out_result,
    output logic                    out_stb,
    input  logic                    out_busy,
    output logic [15:0]             txn_count
);
    localparam logic [CNT_W-1:0] C_N_MAX = CNT_W'(N_OPS);

    state_t                    state_q, state_d;
    logic [BF16_W*N_OPS-1:0]   data_q, data_d;
    logic [CNT_W-1:0]          n_q, n_d, idx_q, idx_d;
    logic [15:0]               acc_q, acc_d, out_result_q, out_result_d, txn_count_q, txn_count_d;
    logic                      busy_q, busy_d, out_stb_q, out_stb_d;
    logic                      mult_stb_q, mult_stb_d, mult_obusy_q, mult_obusy_d;

    logic [CNT_W-1:0] n_clamp;
    logic [15:0]      op_sel, mult_result;
    logic             mult_busy, mult_out_stb;

    assign n_clamp = (in_count > C_N_MAX) ? C_N_MAX : in_count;
    assign op_sel  = data_q[BF16_W*int'(idx_q) +: BF16_W];

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        n_d          = n_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        out_result_d = out_result_q;
        txn_count_d  = txn_count_q;
        busy_d       = busy_q;
        out_stb_d    = out_stb_q;
        mult_stb_d   = mult_stb_q;
        mult_obusy_d = mult_obusy_q;
        case (state_q)
            S_IDLE: if (in_stb) begin
                data_d = in_data;
                n_d    = n_clamp;
                idx_d  = CNT_W'(1);
                busy_d = 1'b1;
                if (n_clamp == '0) begin
                    out_result_d = BF16_ONE;
                    out_stb_d    = 1'b1;
                    state_d      = S_OUT;
                end else if (n_clamp == CNT_W'(1)) begin
                    out_result_d = in_data[15:0];
                    out_stb_d    = 1'b1;
                    state_d      = S_OUT;
                end else begin
                    acc_d      = in_data[15:0];
                    mult_stb_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: if (mult_stb_q && !mult_busy) begin
                mult_stb_d   = 1'b0;
                mult_obusy_d = 1'b0;
                state_d      = S_WAIT;
            end
            S_WAIT: if (mult_out_stb && !mult_obusy_q) begin
                acc_d        = mult_result;
                mult_obusy_d = 1'b1;
                idx_d        = idx_q + CNT_W'(1);
                if (idx_q == n_q - CNT_W'(1)) begin
                    out_result_d = mult_result;
                    out_stb_d    = 1'b1;
                    state_d      = S_OUT;
                end else begin
                    mult_stb_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_OUT: if (!out_busy) begin
                out_stb_d   = 1'b0;
                busy_d      = 1'b0;
                txn_count_d = txn_count_q + 16'd1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            data_q       <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            acc_q        <= 16'd0;
            out_result_q <= 16'd0;
            txn_count_q  <= 16'd0;
            busy_q       <= 1'b0;
            out_stb_q    <= 1'b0;
            mult_stb_q   <= 1'b0;
            mult_obusy_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            out_result_q <= out_result_d;
            txn_count_q  <= txn_count_d;
            busy_q       <= busy_d;
            out_stb_q    <= out_stb_d;
            mult_stb_q   <= mult_stb_d;
            mult_obusy_q <= mult_obusy_d;
        end
    end

    // the multiplier resets active-high, so it sees the inverted block reset
    multiplier_bf16 u_mult (
        .clk      (clk),
        .rst      (~rst),
        .a        (acc_q),
        .b        (op_sel),
        .in_stb   (mult_stb_q),
        .in_busy  (mult_busy),
        .result   (mult_result),
        .out_stb  (mult_out_stb),
        .out_busy (mult_obusy_q)
    );

    assign busy       = busy_q;
    assign out_stb    = out_stb_q;
    assign out_result = out_result_q;
    assign txn_count  = txn_count_q;
endmodule

`default_nettype wire

// File: tb/tb_bf16_chain_multiplier.sv
// ----------------------------------------------------------------------------
// tb_bf16_chain_multiplier : scoreboard bench for bf16_chain_multiplier | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bf16_chain_multiplier;
    localparam int N_OPS = 8;
    localparam int CNT_W = $clog2(N_OPS + 1);
    localparam int DW    = 16 * N_OPS;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [DW-1:0]    in_data = '0;
    logic [CNT_W-1:0] in_count = '0;
    logic             in_stb = 1'b0;
    logic             out_busy = 1'b0;
    logic             busy, out_stb;
    logic [15:0]      out_result, txn_count;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_txn = 16'd0;

    always #5 clk = ~clk;

    bf16_chain_multiplier #(.N_OPS(N_OPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_count   (in_count),
        .in_stb     (in_stb),
        .busy       (busy),
        .out_result (out_result),
        .out_stb    (out_stb),
        .out_busy   (out_busy),
        .txn_count  (txn_count)
    );

    // returns at the negedge right after the accepting posedge
    task automatic send(input logic [DW-1:0] data, input logic [CNT_W-1:0] cnt);
        int waited = 0;
        @(negedge clk);
        in_data  = data;
        in_count = cnt;
        in_stb   = 1'b1;
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL send_accept: busy=%b required 0 after %0d cycles", busy, waited);
        end
        @(negedge clk);
        in_stb = 1'b0;
    endtask

    task automatic wait_out(output logic [15:0] res, output bit seen);
        int waited = 0;
        while (!out_stb && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        seen = out_stb;
        res  = out_result;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (out_stb !== 1'b0) begin failures++; $display("FAIL reset_out_stb: got %b want 0", out_stb); end
        if (out_result !== 16'h0000) begin failures++; $display("FAIL reset_result: got %h want 0000", out_result); end
        if (txn_count !== 16'h0000) begin failures++; $display("FAIL reset_txn: got %h want 0000", txn_count); end
        rst = 1'b1;
        exp_txn = 16'd0;
        @(negedge clk);
    endtask

    task automatic test_chain4;
        logic [15:0] res, exp_v;
        bit seen;
        exp_q.push_back(16'h4140);
        send({64'd0, 16'h4080, 16'h3F00, 16'h4040, 16'h4000}, CNT_W'(4));
        in_data  = '1;
        in_count = '1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL chain4_busy: got %b want 1", busy); end
        wait_out(res, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || res !== exp_v) begin
            failures++;
            $display("FAIL chain4_result: got %h (stb=%b) want %h", res, seen, exp_v);
        end
        @(negedge clk);
        exp_txn++;
        checks += 2;
        if (txn_count !== exp_txn) begin failures++; $display("FAIL chain4_txn: got %h want %h", txn_count, exp_txn); end
        if (out_stb !== 1'b0) begin failures++; $display("FAIL chain4_stb_drop: got %b want 0", out_stb); end
    endtask

    task automatic test_short(input logic [DW-1:0] data, input logic [CNT_W-1:0] cnt,
                              input logic [15:0] expect_v);
        logic [15:0] exp_v;
        exp_q.push_back(expect_v);
        send(data, cnt);
        exp_v = exp_q.pop_front();
        checks += 2;
        if (out_stb !== 1'b1) begin failures++; $display("FAIL short_n%0d_stb: got %b want 1", cnt, out_stb); end
        if (out_result !== exp_v) begin failures++; $display("FAIL short_n%0d_result: got %h want %h", cnt, out_result, exp_v); end
        @(negedge clk);
        exp_txn++;
        checks++;
        if (txn_count !== exp_txn) begin failures++; $display("FAIL short_n%0d_txn: got %h want %h", cnt, txn_count, exp_txn); end
    endtask

    task automatic test_clamp;
        logic [15:0] res, exp_v;
        bit seen;
        exp_q.push_back(16'h4380);
        send({N_OPS{16'h4000}}, CNT_W'(15));
        wait_out(res, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || res !== exp_v) begin
            failures++;
            $display("FAIL clamp_result: got %h (stb=%b) want %h", res, seen, exp_v);
        end
        @(negedge clk);
        exp_txn++;
    endtask

    task automatic test_backpressure;
        logic [15:0] res, exp_v;
        bit seen, extra;
        out_busy = 1'b1;
        exp_q.push_back(16'h40C0);
        send({96'd0, 16'h4040, 16'h4000}, CNT_W'(2));
        wait_out(res, seen);
        exp_v = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_stb !== 1'b1 || out_result !== exp_v) begin
                failures++;
                $display("FAIL hold_cycle%0d: stb=%b result=%h want stb=1 result=%h", i, out_stb, out_result, exp_v);
            end
            in_data  = {N_OPS{16'h4000}};
            in_count = '0;
            in_stb   = (i % 2 == 0) && (i < 9);
            @(negedge clk);
        end
        in_stb   = 1'b0;
        out_busy = 1'b0;
        @(negedge clk);
        exp_txn++;
        checks++;
        if (txn_count !== exp_txn) begin failures++; $display("FAIL hold_txn: got %h want %h", txn_count, exp_txn); end
        extra = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_stb) extra = 1'b1;
        end
        checks++;
        if (extra) begin failures++; $display("FAIL hold_ignored_stb: got extra output want none"); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] res, exp_v;
        bit seen, extra;
        send({N_OPS{16'h4000}}, CNT_W'(8));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_txn = 16'd0;
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (out_stb !== 1'b0) begin failures++; $display("FAIL midrst_stb: got %b want 0", out_stb); end
        if (txn_count !== exp_txn) begin failures++; $display("FAIL midrst_txn: got %h want %h", txn_count, exp_txn); end
        rst = 1'b1;
        extra = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_stb) extra = 1'b1;
        end
        checks++;
        if (extra) begin failures++; $display("FAIL midrst_no_output: got output want none"); end
        exp_q.push_back(16'h40C0);
        send({96'd0, 16'h4040, 16'h4000}, CNT_W'(2));
        wait_out(res, seen);
        exp_v = exp_q.pop_front();
        checks++;
        if (!seen || res !== exp_v) begin
            failures++;
            $display("FAIL midrst_next_result: got %h (stb=%b) want %h", res, seen, exp_v);
        end
        @(negedge clk);
        exp_txn++;
        checks++;
        if (txn_count !== exp_txn) begin failures++; $display("FAIL midrst_next_txn: got %h want %h", txn_count, exp_txn); end
    endtask

    task automatic test_wrap;
        logic [15:0] exp_v;
        force dut.txn_count_q = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.txn_count_q;
        @(negedge clk);
        exp_txn = 16'hFFFF;
        checks++;
        if (txn_count !== exp_txn) begin failures++; $display("FAIL wrap_preset: got %h want %h", txn_count, exp_txn); end
        exp_q.push_back(16'h3F80);
        send('0, '0);
        exp_v = exp_q.pop_front();
        checks++;
        if (out_result !== exp_v) begin failures++; $display("FAIL wrap_result: got %h want %h", out_result, exp_v); end
        @(negedge clk);
        exp_txn++;
        checks++;
        if (txn_count !== exp_txn) begin failures++; $display("FAIL wrap_txn: got %h want %h", txn_count, exp_txn); end
    endtask

    initial begin
        test_reset();
        test_chain4();
        test_short('0, CNT_W'(0), 16'h3F80);
        test_short({96'd0, 16'h4000, 16'hC0A0}, CNT_W'(1), 16'hC0A0);
        test_clamp();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
